// File: rtl/ssp_host_bridge.sv
// ssp_host_bridge: feeds words from a valid/ready stream into the SSP transmit FIFO.
// When the SSP receive FIFO reports full, it drains RX_DEPTH words and returns them
// on a valid/ready output stream.
`ifndef SSP_WORD_SIZE
`define SSP_WORD_SIZE 8
`endif

module ssp_host_bridge #(
    parameter int WORD     = `SSP_WORD_SIZE,
    parameter int RX_DEPTH = 4,
    parameter int RD_LAT   = 2
) (
    input  logic            PCLK,
    input  logic            CLEAR,
    input  logic [WORD-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [WORD-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            PSEL,
    output logic            PWRITE,
    output logic [WORD-1:0] PWDATA,
    input  logic [WORD-1:0] PRDATA,
    input  logic            SSPTXINTR,
    input  logic            SSPRXINTR,
    output logic            busy
);

    localparam int DCW = $clog2(RX_DEPTH + 1);
    localparam int WCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_PUSH
    } state_t;

    state_t          r_state;
    logic [DCW-1:0]  r_drain_cnt;
    logic [WCW-1:0]  r_wait_cnt;
    logic            r_psel;
    logic            r_pwrite;
    logic [WORD-1:0] r_pwdata;
    logic [WORD-1:0] r_rx_data;
    logic            r_rx_valid;
    logic [DCW-1:0]  w_drain_dec;

    assign w_drain_dec = r_drain_cnt - DCW'(1);

    // Accept a transmit word only when idle and neither SSP FIFO is signalling full.
    assign tx_ready = (r_state == S_IDLE) & ~SSPRXINTR & ~SSPTXINTR & ~CLEAR;
    assign busy     = (r_state != S_IDLE);
    assign PSEL     = r_psel;
    assign PWRITE   = r_pwrite;
    assign PWDATA   = r_pwdata;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;

    // Bridge FSM; strobes are set on entry to WRITE/READ so they last exactly one cycle.
    always_ff @(posedge PCLK or posedge CLEAR) begin
        if (CLEAR) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_wait_cnt  <= '0;
            r_psel      <= 1'b0;
            r_pwrite    <= 1'b0;
            r_pwdata    <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (SSPRXINTR) begin
                        r_state     <= S_READ;
                        r_drain_cnt <= DCW'(RX_DEPTH);
                        r_psel      <= 1'b1;
                        r_pwrite    <= 1'b0;
                    end else if (tx_valid && tx_ready) begin
                        r_state  <= S_WRITE;
                        r_pwdata <= tx_data;
                        r_psel   <= 1'b1;
                        r_pwrite <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_state  <= S_IDLE;
                    r_psel   <= 1'b0;
                    r_pwrite <= 1'b0;
                end
                S_READ: begin
                    r_state    <= S_WAIT;
                    r_wait_cnt <= WCW'(RD_LAT - 1);
                    r_psel     <= 1'b0;
                    r_pwrite   <= 1'b0;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state    <= S_PUSH;
                        r_rx_data  <= PRDATA;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - WCW'(1);
                    end
                end
                S_PUSH: begin
                    if (rx_ready) begin
                        r_rx_valid  <= 1'b0;
                        r_drain_cnt <= w_drain_dec;
                        if (w_drain_dec != '0) begin
                            r_state  <= S_READ;
                            r_psel   <= 1'b1;
                            r_pwrite <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_psel   <= 1'b0;
                    r_pwrite <= 1'b0;
                end
            endcase
        end
    end

endmodule
